// File: rtl/result_drain_buffer.sv
// Result drain buffer: captures the N*N accumulator results streamed out of the
// systolic array and replays them to the host through a pop-style read port.
module result_drain_buffer #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       drain_valid_i,
  input  logic [DATA_WIDTH-1:0]      drain_data_i,
  input  logic                       read_enable_i,
  input  logic                       read_reset_i,
  output logic [DATA_WIDTH-1:0]      read_data_o,
  output logic                       read_valid_o,
  output logic                       capture_done_o,
  output logic                       buffer_empty_o,
  output logic                       buffer_full_o,
  output logic                       overflow_o,
  output logic [$clog2(N*N+1)-1:0]   count_o
);

  localparam int DEPTH = N * N;
  localparam int PW    = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] FULL = PW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [PW-1:0]           wptr;
  logic [PW-1:0]           wptr_next;
  logic [PW-1:0]           rptr;
  logic [PW-1:0]           rptr_next;
  logic                    mem_we;
  logic [AW-1:0]           mem_waddr;
  logic                    rd_accept;
  logic                    rvalid_next;
  logic                    done_next;
  logic                    ovf_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Next-state, pointer and flag decode; start_i overrides every state.
  always_comb begin
    state_next  = state;
    wptr_next   = wptr;
    rptr_next   = rptr;
    mem_we      = 1'b0;
    mem_waddr   = wptr[AW-1:0];
    rd_accept   = 1'b0;
    rvalid_next = 1'b0;
    done_next   = capture_done_o;
    ovf_next    = overflow_o;
    if (start_i) begin
      state_next = CAPTURE;
      rptr_next  = {PW{1'b0}};
      done_next  = 1'b0;
      ovf_next   = 1'b0;
      mem_waddr  = {AW{1'b0}};
      if (drain_valid_i) begin
        mem_we    = 1'b1;
        wptr_next = PW'(1);
      end else begin
        wptr_next = {PW{1'b0}};
      end
    end else begin
      case (state)
        IDLE: begin
          state_next = IDLE;
        end
        CAPTURE: begin
          if (drain_valid_i) begin
            mem_we    = 1'b1;
            wptr_next = wptr + PW'(1);
            if (wptr == LAST) begin
              state_next = READY;
              done_next  = 1'b1;
            end else begin
              state_next = CAPTURE;
            end
          end else begin
            state_next = CAPTURE;
          end
        end
        READY: begin
          // Late beats are dropped but remembered until the next start.
          if (drain_valid_i) begin
            ovf_next = 1'b1;
          end else begin
            ovf_next = overflow_o;
          end
          if (read_reset_i) begin
            rptr_next = {PW{1'b0}};
          end else if (read_enable_i && (rptr < FULL)) begin
            rd_accept   = 1'b1;
            rvalid_next = 1'b1;
            rptr_next   = rptr + PW'(1);
          end else begin
            rptr_next = rptr;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Control registers and registered read port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      wptr           <= {PW{1'b0}};
      rptr           <= {PW{1'b0}};
      read_data_o    <= {DATA_WIDTH{1'b0}};
      read_valid_o   <= 1'b0;
      capture_done_o <= 1'b0;
      overflow_o     <= 1'b0;
    end else begin
      state          <= state_next;
      wptr           <= wptr_next;
      rptr           <= rptr_next;
      read_valid_o   <= rvalid_next;
      capture_done_o <= done_next;
      overflow_o     <= ovf_next;
      if (rd_accept) begin
        read_data_o <= mem[rptr[AW-1:0]];
      end else begin
        read_data_o <= read_data_o;
      end
    end
  end

  // Result storage; contents intentionally survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= drain_data_i;
    end
  end

  assign count_o        = wptr;
  assign buffer_full_o  = (wptr == FULL);
  assign buffer_empty_o = (rptr == wptr);

endmodule

// File: doc/result_drain_buffer.md
Name: result_drain_buffer

Overview:
- Output-side counterpart of the systolic array's north/west input queues.
- Captures the N*N accumulator results that the mesh streams out on its drain interface (drain data plus drain valid from the top-right PE).
- Holds the results in a local buffer and returns them to the host through a read interface that mirrors the queues' write interface (enable, data, pointer reset).
- Sits beside the array top level and feeds the host/DMA side.

Parameters:
- N, 8, array dimension; buffer depth is N*N entries.
- DATA_WIDTH, 32, width of each result word.

Ports:
- clk_i  input  1  single clock; all logic on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  arm a new capture; clears pointers and flags.
- drain_valid_i  input  1  drain beat valid from the array.
- drain_data_i  input  DATA_WIDTH  drain beat data from the array.
- read_enable_i  input  1  pop one result.
- read_reset_i  input  1  rewind read pointer to 0 (replay).
- read_data_o  output  DATA_WIDTH  registered read data.
- read_valid_o  output  1  read_data_o valid this cycle.
- capture_done_o  output  1  all N*N results captured; level signal.
- buffer_empty_o  output  1  no unread results.
- buffer_full_o  output  1  N*N entries captured.
- overflow_o  output  1  sticky; drain beat arrived while not capturing a free slot.
- count_o  output  $clog2(N*N+1)  number of entries captured.

Behaviour:
- Reset (async assert, sync deassert use):
  - State is IDLE.
  - wptr = 0, rptr = 0.
  - read_data_o = 0, read_valid_o = 0, capture_done_o = 0.
  - buffer_empty_o = 1, buffer_full_o = 0, overflow_o = 0, count_o = 0.
  - Memory contents are not reset.
- Storage: N*N x DATA_WIDTH array. Entry k holds the k-th drain beat after start, in row-major result order.
- State machine IDLE / CAPTURE / READY:
  - IDLE: drain_valid_i is ignored and not flagged. read_enable_i is ignored. start_i -> CAPTURE.
  - CAPTURE: each cycle with drain_valid_i=1 writes mem[wptr] and increments wptr. The write of entry N*N-1 moves to READY; capture_done_o rises the next cycle. Reads are ignored and read_valid_o stays 0.
  - READY: drain_valid_i=1 sets overflow_o; the data is dropped. start_i -> CAPTURE.
- start_i in any state:
  - Clears wptr, rptr, capture_done_o and overflow_o.
  - Deasserts read_valid_o next cycle.
  - A drain_valid_i in the same cycle as start_i is captured as entry 0.
- Read (READY only):
  - read_enable_i with rptr < N*N: read_data_o <= mem[rptr], read_valid_o <= 1, rptr++. Latency is 1 cycle.
  - read_enable_i with rptr == N*N (empty): read_valid_o <= 0, read_data_o holds, rptr unchanged. No error flag is raised.
  - read_valid_o is otherwise 0 on every cycle without an accepted read.
  - read_reset_i: rptr <= 0. It wins over read_enable_i in the same cycle (no data returned that cycle).
- Flags:
  - count_o = wptr.
  - buffer_full_o = (wptr == N*N).
  - buffer_empty_o = (rptr == wptr). It is also 1 in CAPTURE before any beat, and 1 after the final read.
- Pointer widths are $clog2(N*N+1). No wrap-around: wptr saturates at N*N and rptr stops at N*N.
- overflow_o stays high until start_i or reset.
- Reset asserted mid-capture or mid-read: immediate return to reset values. Partial data is discarded; a new start_i is required.

Test Plan:
- N=2, DATA_WIDTH=32: start_i, then 4 back-to-back drain beats 0x11, 0x22, 0x33, 0x44 -> capture_done_o=1 one cycle after the 4th beat, count_o=4, buffer_full_o=1. Then 4 consecutive read_enable_i -> read_data_o 0x11, 0x22, 0x33, 0x44 each 1 cycle after its enable, read_valid_o high 4 cycles, then buffer_empty_o=1.
- Gapped drain (valid 1,0,0,1,1,0,1) -> exactly 4 entries in arrival order, count_o steps 1..4. Reads issued during CAPTURE -> read_valid_o=0.
- After full readout: read_enable_i -> read_valid_o=0, data held. read_reset_i together with read_enable_i -> no valid that cycle; next read returns 0x11.
- In READY, a drain beat 0xDEAD -> overflow_o=1 (sticky), buffer contents unchanged on readback. start_i -> overflow_o=0, count_o=0, state CAPTURE.
- rst_i asserted after 2 of 4 beats -> all outputs at reset values immediately. Beats without start_i are ignored. A fresh start_i plus 4 beats completes normally.
- start_i coincident with drain beat 0x55 -> 0x55 stored as entry 0, count_o=1 next cycle.
